// File: rtl/tl_left_sched_pkg.sv
// Shared state codes, lamp codes and default timing for the left-turn
// traffic-light sequencer.
package tl_left_sched_pkg;

    typedef enum logic [2:0] {
        S0 = 3'b000, S1 = 3'b001, S2 = 3'b010, S3 = 3'b011,
        S4 = 3'b100, S5 = 3'b101, S6 = 3'b110, S7 = 3'b111
    } state_t;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        LEFT   = 2'b10,
        RED    = 2'b11
    } lamp_t;

    localparam int GREEN_MIN_D = 4;
    localparam int GREEN_MAX_D = 10;
    localparam int YELLOW_T_D  = 2;
    localparam int LEFT_T_D    = 3;
    localparam int CNT_W_D     = 4;

endpackage

// File: rtl/tl_left_sched_if.sv
// Sensor/request inputs and lamp/phase outputs of the sequencer.
interface tl_left_sched_if;
    logic       Ta;
    logic       Tb;
    logic       La_req;
    logic       Lb_req;
    logic [1:0] La;
    logic [1:0] Lb;
    logic [2:0] q;

    modport master (output Ta, Tb, La_req, Lb_req, input La, Lb, q);
    modport slave  (input Ta, Tb, La_req, Lb_req, output La, Lb, q);
endinterface

// File: rtl/tl_lamp_dec.sv
// Combinational phase-state to lamp-code decoder; the idle street is always red.
module tl_lamp_dec (
    input  logic [2:0] q,
    output logic [1:0] La,
    output logic [1:0] Lb
);
    assign La[1] = q[2]  | (q[1] & ~q[0]);
    assign La[0] = q[2]  | q[0];
    assign Lb[1] = ~q[2] | (q[1] & ~q[0]);
    assign Lb[0] = ~q[2] | q[0];
endmodule

// File: rtl/tl_left_sched.sv
// Timed two-street phase sequencer with latched protected left-turn requests.
module tl_left_sched
    import tl_left_sched_pkg::*;
#(
    parameter int GREEN_MIN = GREEN_MIN_D,
    parameter int GREEN_MAX = GREEN_MAX_D,
    parameter int YELLOW_T  = YELLOW_T_D,
    parameter int LEFT_T    = LEFT_T_D,
    parameter int CNT_W     = CNT_W_D
) (
    input  logic           clk,
    input  logic           reset_n,
    tl_left_sched_if.slave bus
);
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] LEFT_LAST = CNT_W'(LEFT_T - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             la_pend, lb_pend, la_pend_nx, lb_pend_nx;
    logic             la_serve, lb_serve;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S0;
            cnt     <= '0;
            la_pend <= 1'b0;
            lb_pend <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            la_pend <= la_pend_nx;
            lb_pend <= lb_pend_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S0: if ((cnt >= GMIN_LAST && !bus.Ta) || cnt == GMAX_LAST) state_nx = S1;
            S1: if (cnt == YEL_LAST) state_nx = (la_pend | bus.La_req) ? S2 : S4;
            S2: if (cnt == LEFT_LAST) state_nx = S3;
            S3: if (cnt == YEL_LAST) state_nx = S4;
            S4: if ((cnt >= GMIN_LAST && !bus.Tb) || cnt == GMAX_LAST) state_nx = S5;
            S5: if (cnt == YEL_LAST) state_nx = (lb_pend | bus.Lb_req) ? S6 : S0;
            S6: if (cnt == LEFT_LAST) state_nx = S7;
            S7: if (cnt == YEL_LAST) state_nx = S0;
            default: state_nx = S0;
        endcase

        cnt_nx = (state_nx != state) ? '0 : cnt + 1'b1;

        // Entering the left phase serves the request; that beats a new set.
        la_serve   = (state == S1) && (state_nx == S2);
        lb_serve   = (state == S5) && (state_nx == S6);
        la_pend_nx = (la_pend | bus.La_req) & ~la_serve;
        lb_pend_nx = (lb_pend | bus.Lb_req) & ~lb_serve;
    end

    assign bus.q = state;

    tl_lamp_dec u_dec (
        .q  (state),
        .La (bus.La),
        .Lb (bus.Lb)
    );
endmodule

// File: tb/tb_tl_left_sched.sv
// Randomized and directed checks of tl_left_sched against a phase-level model.
module tb_tl_left_sched;
    localparam int GMIN = 4;
    localparam int GMAX = 10;
    localparam int YT   = 2;
    localparam int LT   = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tl_left_sched_if itf ();

    tl_left_sched dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (itf.slave)
    );

    int total = 0;
    int bad   = 0;

    // Model: active street (0=A,1=B), phase kind (0 green,1 yellow,2 left,3 left-yellow)
    int m_st, m_kind, m_el;
    bit m_pend [2];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lamp(input int street);
        if (street != m_st) return 3;
        case (m_kind)
            0:       return 0;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_st = 0; m_kind = 0; m_el = 0;
        m_pend[0] = 1'b0; m_pend[1] = 1'b0;
    endtask

    task automatic model_step(input bit ta, input bit tb, input bit ra, input bit rb);
        int ost   = m_st;
        int okind = m_kind;
        bit served = 1'b0;
        bit t = (m_st == 0) ? ta : tb;
        bit r = (m_st == 0) ? ra : rb;
        case (m_kind)
            0: if ((m_el >= GMIN - 1 && !t) || m_el == GMAX - 1) m_kind = 1;
            1: if (m_el == YT - 1) begin
                   if (m_pend[m_st] || r) begin m_kind = 2; served = 1'b1; end
                   else begin m_st = 1 - m_st; m_kind = 0; end
               end
            2: if (m_el == LT - 1) m_kind = 3;
            default: if (m_el == YT - 1) begin m_st = 1 - m_st; m_kind = 0; end
        endcase
        m_pend[0] = (served && ost == 0) ? 1'b0 : (m_pend[0] | ra);
        m_pend[1] = (served && ost == 1) ? 1'b0 : (m_pend[1] | rb);
        m_el = (m_st != ost || m_kind != okind) ? 0 : m_el + 1;
    endtask

    task automatic check_now();
        chk("q", int'(itf.q), m_st * 4 + m_kind);
        chk("La", int'(itf.La), lamp(0));
        chk("Lb", int'(itf.Lb), lamp(1));
        chk("la_pend", int'(dut.la_pend), int'(m_pend[0]));
        chk("lb_pend", int'(dut.lb_pend), int'(m_pend[1]));
        chk("both_go", int'(itf.La != 2'b11 && itf.Lb != 2'b11), 0);
    endtask

    task automatic step(input bit ta, input bit tb, input bit ra, input bit rb);
        itf.Ta = ta; itf.Tb = tb; itf.La_req = ra; itf.Lb_req = rb;
        @(posedge clk);
        model_step(ta, tb, ra, rb);
        #1;
        check_now();
    endtask

    task automatic do_reset();
        itf.Ta = 1'b0; itf.Tb = 1'b0; itf.La_req = 1'b0; itf.Lb_req = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        reset_n = 1'b1;
        check_now();
    endtask

    initial begin
        int n;
        bit hit;
        logic [2:0] held;
        logic [2:0] prev;
        int run;
        bit armed;

        do_reset();
        chk("rst_q", int'(itf.q), 0);

        // Light traffic: 12-cycle period, reset observation is index 0
        for (int k = 1; k < 24; k++) begin
            if (k == 5) begin
                held = itf.q;
                reset_n = 1'b0;
                #2;
                reset_n = 1'b1;
                chk("rst_no_edge", int'(itf.q), int'(held));
            end
            step(0, 0, 0, 0);
            chk("light_La", int'(itf.La), (k % 12 < 4) ? 0 : (k % 12 < 6) ? 1 : 3);
        end

        // Starvation cap
        do_reset();
        n = 1;
        for (int i = 0; i < 30; i++) begin
            step(1, 0, 0, 0);
            if (itf.q != 3'd0) break;
            n++;
        end
        chk("starve_len", n, GMAX);
        chk("starve_La", int'(itf.La), 1);

        // Left turn via a one-cycle pulse in S0
        do_reset();
        step(1, 0, 1, 0);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step(0, 0, 0, 0);
            if (itf.q == 3'd2) hit = 1'b1;
        end
        chk("left_reach", int'(hit), 1);
        chk("left_pend_clr", int'(dut.la_pend), 0);
        chk("left_La", int'(itf.La), 2);
        n = 1;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            if (itf.q != 3'd2) break;
            n++;
        end
        chk("left_len", n, LT);
        chk("left_then", int'(itf.q), 3);

        // Late request on the last S1 cycle, then a request only in S2
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step(0, 0, 0, 0);
            if (itf.q == 3'd1) hit = 1'b1;
        end
        chk("late_s1", int'(hit), 1);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("late_to_s2", int'(itf.q), 2);
        step(0, 0, 1, 0);
        chk("s2_req_latched", int'(dut.la_pend), 1);
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            step(0, 0, 0, 0);
            if (itf.q == 3'd4) hit = 1'b1;
        end
        chk("late_to_b", int'(hit), 1);
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            step(0, 0, 0, 0);
            if (itf.q == 3'd2) hit = 1'b1;
        end
        chk("late_served", int'(hit), 1);

        // Reset while in S6
        do_reset();
        step(0, 0, 0, 1);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step(0, 0, 0, 0);
            if (itf.q == 3'd6) hit = 1'b1;
        end
        chk("s6_reach", int'(hit), 1);
        step(0, 0, 1, 0);
        do_reset();
        chk("s6_rst_q", int'(itf.q), 0);
        chk("s6_rst_La", int'(itf.La), 0);
        chk("s6_rst_Lb", int'(itf.Lb), 3);
        chk("s6_rst_la_pend", int'(dut.la_pend), 0);

        // Random traffic with phase-length tracking
        prev = itf.q;
        run = 1;
        armed = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0));
            if (itf.q == prev) run++;
            else begin
                if (armed && prev[1:0] != 2'd0)
                    chk("phase_len", run, (prev[1:0] == 2'd2) ? LT : YT);
                armed = 1'b1;
                run = 1;
                prev = itf.q;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tl_left_sched.md
Name: tl_left_sched

Overview:
Timed phase sequencer for the two-street traffic-light controller with protected left-turn phases.
- Holds the 3-bit phase state, per-phase duration counter and latched left-turn requests.
- Drives the 2-bit lamp codes La (street A) and Lb (street B) through a state-to-lamp decoder.
- Sits between the vehicle sensors / left-turn request buttons and the lamp drivers.

Parameters:
GREEN_MIN, 4, minimum cycles a through-green phase is held
GREEN_MAX, 10, maximum cycles a through-green phase is held (anti-starvation); must be >= GREEN_MIN
YELLOW_T, 2, cycles of every yellow phase
LEFT_T, 3, cycles of every left-turn phase
CNT_W, 4, phase counter width; must satisfy 2^CNT_W > max(GREEN_MAX, YELLOW_T, LEFT_T)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  synchronous active-low reset
Ta  input  1  through-traffic present on street A
Tb  input  1  through-traffic present on street B
La_req  input  1  left-turn request, street A (pulse or level)
Lb_req  input  1  left-turn request, street B (pulse or level)
La  output  2  street A lamp: 00 green, 01 yellow, 10 left-arrow, 11 red
Lb  output  2  street B lamp, same encoding
q  output  3  current phase state (debug/observe)

Behaviour:
- One clock domain. Reset is synchronous and active-low: sampled only on a rising clk edge while reset_n=0.
- Reset values: q=000 (S0), cnt=0, both request latches 0. Hence La=00, Lb=11. Reset mid-phase aborts the phase at that edge.
- La and Lb are a combinational decode of q; they change in the same cycle as q. No added latency.
- States and lamps (La/Lb):
  - S0=000 A green, 00/11
  - S1=001 A yellow, 01/11
  - S2=010 A left, 10/11
  - S3=011 A left-yellow, 01/11
  - S4=100 B green, 11/00
  - S5=101 B yellow, 11/01
  - S6=110 B left, 11/10
  - S7=111 B left-yellow, 11/01
- cnt clears to 0 on every state change. Otherwise it increments by 1 each cycle. It never exceeds GREEN_MAX-1.
- Transitions; "done(N)" means cnt==N-1:
  - S0 -> S1 when (cnt>=GREEN_MIN-1 and Ta==0) or done(GREEN_MAX). Otherwise stay in S0.
  - S1 -> S2 at done(YELLOW_T) if (la_pend | La_req); otherwise S1 -> S4.
  - S2 -> S3 at done(LEFT_T).
  - S3 -> S4 at done(YELLOW_T).
  - S4..S7 mirror S0..S3, using Tb, lb_pend/Lb_req and target S0.
- Request latches:
  - la_pend is set by La_req=1 in any state.
  - la_pend is cleared on the S1 -> S2 edge.
  - If set and clear coincide, clear wins: the request is being served.
  - A request arriving during S2/S3 is latched and served in the next A cycle.
  - lb_pend behaves symmetrically.
- Whole-cycle total: a phase never lasts 0 cycles.
  - A left-turn cycle = green + YELLOW_T + LEFT_T + YELLOW_T.
  - A cycle without left turn = green + YELLOW_T.
- Both streets are never non-red in the same cycle. Verification holds this as an invariant.
- Unknown q values cannot occur; the default branch returns to S0.

Decomposition:
- Shared package/defines file holds:
  - state codes S0..S7
  - lamp codes GREEN=2'b00, YELLOW=2'b01, LEFT=2'b10, RED=2'b11
  - default timing constants
- One sub-module is natural: tl_lamp_dec. It is purely combinational q[2:0] -> La, Lb:
  - La[1] = q2 | q1&~q0
  - La[0] = q2 | q0
  - Lb[1] = ~q2 | q1&~q0
  - Lb[0] = ~q2 | q0
- The sequencer holds the state register, counter and latches.

Test Plan:
- Reset: reset_n=0 for 1 edge while in S6 -> next cycle q=000, La=00, Lb=11, both request latches 0. Reset_n=0 without a clk edge has no effect.
- Light traffic: Ta=Tb=0, no requests, from reset -> S0 for 4 cycles, S1 for 2, S4 for 4, S5 for 2, back to S0. Period 12 cycles; La sequence 00x4, 01x2, 11x6.
- Starvation cap: Ta=1 held -> S0 lasts exactly 10 cycles, then S1 (La=01).
- A left turn: La_req pulse for 1 cycle during S0 -> S0, then S1 (2), S2 (3, La=10, Lb=11), S3 (2, La=01), then S4. la_pend is 0 from the first S2 cycle.
- Late request: La_req=1 only on the last S1 cycle, with la_pend=0 -> next state S2, not S4. La_req=1 only in S2 -> served in the next A cycle's S2.
- Safety: random Ta/Tb/La_req/Lb_req for 10k cycles -> never both La!=11 and Lb!=11. Every yellow phase lasts exactly 2 cycles and every left phase exactly 3.
